updowncount_mod: RTL

Parametrised successor to the 4-bit up/down counter. Adds configurable width and terminal value (modulo-N counting), count enable, synchronous clear and load, wrap or saturate mode, a registered terminal-count pulse and sticky overflow/underflow flags. Used as a general event/position counter in datapath and control blocks; one instance per counted quantity.

---
 rtl/updowncount_pkg.sv | 25 ++
 rtl/updowncount_prescaler.sv | 41 ++++
 rtl/updowncount_mod.sv | 113 +++++++++++
 3 files changed

// File: rtl/updowncount_pkg.sv
// Shared constants and elaboration helpers for the updowncount_mod counter.
// The optional enable prescaler is selected by UPDOWNCOUNT_PRESCALE_EN.
package updowncount_pkg;

    // Direction encoding for up_down
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // Boundary behaviour encoding for sat_mode
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // True when the terminal value fits the counter width: 1 <= max_val <= 2**width-1.
    // Widths above 31 are rejected because MAX_VAL is carried as an int.
    function automatic bit max_val_legal(input int width, input longint max_val);
        longint limit;
        if ((width < 2) || (width > 31)) begin
            return 1'b0;
        end else begin
            limit = (longint'(1) << width) - longint'(1);
            return (max_val >= longint'(1)) && (max_val <= limit);
        end
    endfunction

endpackage : updowncount_pkg

// File: rtl/updowncount_prescaler.sv
// Enable divider: issues one step for every PRESCALE cycles with en high.
// Only instantiated when UPDOWNCOUNT_PRESCALE_EN is defined.
module updowncount_prescaler
    import updowncount_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sync_clr,
    output logic step_out
);

    localparam int          CW     = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST_C = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    logic [CW-1:0] phase_r;

    // Phase counter: advances only while en is high, holds otherwise, wraps on the issued step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_r <= {CW{1'b0}};
        end else if (sync_clr) begin
            phase_r <= {CW{1'b0}};
        end else if (en) begin
            if (phase_r == LAST_C) begin
                phase_r <= {CW{1'b0}};
            end else begin
                phase_r <= phase_r + ONE_C;
            end
        end else begin
            phase_r <= phase_r;
        end
    end

    // The step coincides with the enabled cycle that completes the period, so no extra latency
    assign step_out = en && (phase_r == LAST_C);

endmodule : updowncount_prescaler

// File: rtl/updowncount_mod.sv
// Parametrised modulo-N up/down counter with wrap/saturate modes, a registered
// terminal-count pulse and sticky overflow/underflow flags.
// Optional feature macro: UPDOWNCOUNT_PRESCALE_EN (divides en by PRESCALE).
module updowncount_mod
    import updowncount_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             sat_mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    // Reject illegal configurations while elaborating
    generate
        if (!max_val_legal(WIDTH, longint'(MAX_VAL))) begin : g_bad_max
            $fatal(1, "updowncount_mod: MAX_VAL=%0d illegal for WIDTH=%0d", MAX_VAL, WIDTH);
        end
        if (PRESCALE < 2) begin : g_bad_prescale
            $fatal(1, "updowncount_mod: PRESCALE=%0d must be >= 2", PRESCALE);
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             ovf_r;
    logic             unf_r;
    logic             step_s;

`ifdef UPDOWNCOUNT_PRESCALE_EN
    logic sync_clr_s;

    // clear and load both restart the prescaler phase
    assign sync_clr_s = clear | load;

    updowncount_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sync_clr (sync_clr_s),
        .step_out (step_s)
    );
`else
    assign step_s = en;
`endif

    // Counter state: clear beats load beats step; boundaries never compute past MAX_VAL or below 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= ZERO_C;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else if (clear) begin
            count_r <= ZERO_C;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else if (load) begin
            count_r <= (load_val > MAX_C) ? MAX_C : load_val;
            tc_r    <= 1'b0;
        end else if (step_s) begin
            if (up_down == DIR_UP) begin
                if (count_r == MAX_C) begin
                    count_r <= (sat_mode == MODE_SAT) ? MAX_C : ZERO_C;
                    tc_r    <= 1'b1;
                    ovf_r   <= 1'b1;
                end else begin
                    count_r <= count_r + ONE_C;
                    tc_r    <= 1'b0;
                end
            end else begin
                if (count_r == ZERO_C) begin
                    count_r <= (sat_mode == MODE_SAT) ? ZERO_C : MAX_C;
                    tc_r    <= 1'b1;
                    unf_r   <= 1'b1;
                end else begin
                    count_r <= count_r - ONE_C;
                    tc_r    <= 1'b0;
                end
            end
        end else begin
            tc_r <= 1'b0;
        end
    end

    assign count  = count_r;
    assign tc     = tc_r;
    assign ovf    = ovf_r;
    assign unf    = unf_r;
    assign at_max = (count_r == MAX_C);
    assign at_min = (count_r == ZERO_C);

endmodule : updowncount_mod
